// File: rtl/ooo_pkg.sv
// Shared definitions for the issue/execute slice: widths, opcodes, packet field offsets
// and the operand-bypass helper.
package ooo_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned ENTRY_W = 57;
  localparam int unsigned FWD_W   = 23;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd5;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd6;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd7;
  localparam logic [OP_W-1:0] OP_MOV  = 4'd8;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd9;

  // Entry field offsets (LSB of each multi-bit field)
  localparam int unsigned E_VALID     = 56;
  localparam int unsigned E_OP_LSB    = 52;
  localparam int unsigned E_ROB_LSB   = 46;
  localparam int unsigned E_LOOKA_LSB = 40;
  localparam int unsigned E_LOOKB_LSB = 34;
  localparam int unsigned E_VALA_LSB  = 18;
  localparam int unsigned E_VALB_LSB  = 2;
  localparam int unsigned E_USEA      = 1;
  localparam int unsigned E_USEB      = 0;

  // Forward packet offsets
  localparam int unsigned F_VALID   = 22;
  localparam int unsigned F_TAG_LSB = 16;
  localparam int unsigned F_VAL_LSB = 0;

  function automatic logic [FWD_W-1:0] fwd_pkt(input logic             valid,
                                               input logic [TAG_W-1:0]  tag,
                                               input logic [DATA_W-1:0] value);
    return {valid, tag, value};
  endfunction

  // Returns {resolved, value}; the lowest-lettered matching bus wins.
  function automatic logic [DATA_W:0] resolve_operand(input logic              pend,
                                                      input logic [TAG_W-1:0]  look,
                                                      input logic [DATA_W-1:0] stored,
                                                      input logic [FWD_W-1:0]  bus_a,
                                                      input logic [FWD_W-1:0]  bus_b,
                                                      input logic [FWD_W-1:0]  bus_c,
                                                      input logic [FWD_W-1:0]  bus_d);
    logic [DATA_W:0] res;
    res = '0;
    if (!pend) begin
      res = {1'b1, stored};
    end else if (bus_a[F_VALID] && bus_a[F_TAG_LSB +: TAG_W] == look) begin
      res = {1'b1, bus_a[F_VAL_LSB +: DATA_W]};
    end else if (bus_b[F_VALID] && bus_b[F_TAG_LSB +: TAG_W] == look) begin
      res = {1'b1, bus_b[F_VAL_LSB +: DATA_W]};
    end else if (bus_c[F_VALID] && bus_c[F_TAG_LSB +: TAG_W] == look) begin
      res = {1'b1, bus_c[F_VAL_LSB +: DATA_W]};
    end else if (bus_d[F_VALID] && bus_d[F_TAG_LSB +: TAG_W] == look) begin
      res = {1'b1, bus_d[F_VAL_LSB +: DATA_W]};
    end
    return res;
  endfunction

endpackage

// File: rtl/alu16.sv
// Combinational 16-bit ALU lane. MUL is not handled here; it yields 0 like the
// unassigned opcodes.
module alu16
  import ooo_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_SHL:  result_o = a_i << b_i[3:0];
      OP_SHR:  result_o = a_i >> b_i[3:0];
      OP_MOV:  result_o = b_i;
      OP_SLTU: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/issue_exec.sv
// Dual-issue in-order execute stage: picks 0/1/2 head entries, runs them on two ALU
// lanes (lane 0 also owns a 2-cycle multiplier) and broadcasts registered results.
module issue_exec
  import ooo_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] entry0,
  input  logic [ENTRY_W-1:0] entry1,
  input  logic [FWD_W-1:0]   fwdInA,
  input  logic [FWD_W-1:0]   fwdInB,
  input  logic [FWD_W-1:0]   fwdInC,
  input  logic [FWD_W-1:0]   fwdInD,
  output logic [1:0]         taken,
  output logic [FWD_W-1:0]   fwd0,
  output logic [FWD_W-1:0]   fwd1
);

  logic [OP_W-1:0]   op0, op1;
  logic [TAG_W-1:0]  rob0, rob1;
  logic [DATA_W:0]   res0_a, res0_b, res1_a, res1_b;
  logic              ready0, ready1;
  logic [DATA_W-1:0] alu0_res, alu1_res;
  logic [DATA_W-1:0] mul_prod;

  logic [FWD_W-1:0]  fwd0_d, fwd0_q, fwd1_d, fwd1_q;
  logic              mul_busy_d, mul_busy_q;
  logic [DATA_W-1:0] mul_a_d, mul_a_q, mul_b_d, mul_b_q;
  logic [TAG_W-1:0]  mul_rob_d, mul_rob_q;

  assign op0  = entry0[E_OP_LSB +: OP_W];
  assign op1  = entry1[E_OP_LSB +: OP_W];
  assign rob0 = entry0[E_ROB_LSB +: TAG_W];
  assign rob1 = entry1[E_ROB_LSB +: TAG_W];

  assign res0_a = resolve_operand(entry0[E_USEA], entry0[E_LOOKA_LSB +: TAG_W],
                                  entry0[E_VALA_LSB +: DATA_W], fwdInA, fwdInB, fwdInC, fwdInD);
  assign res0_b = resolve_operand(entry0[E_USEB], entry0[E_LOOKB_LSB +: TAG_W],
                                  entry0[E_VALB_LSB +: DATA_W], fwdInA, fwdInB, fwdInC, fwdInD);
  assign res1_a = resolve_operand(entry1[E_USEA], entry1[E_LOOKA_LSB +: TAG_W],
                                  entry1[E_VALA_LSB +: DATA_W], fwdInA, fwdInB, fwdInC, fwdInD);
  assign res1_b = resolve_operand(entry1[E_USEB], entry1[E_LOOKB_LSB +: TAG_W],
                                  entry1[E_VALB_LSB +: DATA_W], fwdInA, fwdInB, fwdInC, fwdInD);

  assign ready0 = entry0[E_VALID] & res0_a[DATA_W] & res0_b[DATA_W];
  assign ready1 = entry1[E_VALID] & res1_a[DATA_W] & res1_b[DATA_W];

  // MUL only issues from slot 0 and never pairs, so entry1 is never taken alone.
  always_comb begin
    taken = 2'd0;
    if (!flush && !mul_busy_q && ready0) begin
      if (op0 == OP_MUL || !ready1 || op1 == OP_MUL) begin
        taken = 2'd1;
      end else begin
        taken = 2'd2;
      end
    end
  end

  alu16 u_alu0 (
    .op_i     (op0),
    .a_i      (res0_a[DATA_W-1:0]),
    .b_i      (res0_b[DATA_W-1:0]),
    .result_o (alu0_res)
  );

  alu16 u_alu1 (
    .op_i     (op1),
    .a_i      (res1_a[DATA_W-1:0]),
    .b_i      (res1_b[DATA_W-1:0]),
    .result_o (alu1_res)
  );

  assign mul_prod = mul_a_q * mul_b_q;

  always_comb begin
    fwd0_d     = '0;
    fwd1_d     = '0;
    mul_busy_d = 1'b0;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_rob_d  = mul_rob_q;
    if (flush) begin
      mul_a_d   = '0;
      mul_b_d   = '0;
      mul_rob_d = '0;
    end else if (mul_busy_q) begin
      fwd0_d = fwd_pkt(1'b1, mul_rob_q, mul_prod);
    end else begin
      if (taken != 2'd0) begin
        if (op0 == OP_MUL) begin
          mul_busy_d = 1'b1;
          mul_a_d    = res0_a[DATA_W-1:0];
          mul_b_d    = res0_b[DATA_W-1:0];
          mul_rob_d  = rob0;
        end else begin
          fwd0_d = fwd_pkt(1'b1, rob0, alu0_res);
        end
      end
      if (taken == 2'd2) begin
        fwd1_d = fwd_pkt(1'b1, rob1, alu1_res);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd0_q     <= '0;
      fwd1_q     <= '0;
      mul_busy_q <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_rob_q  <= '0;
    end else begin
      fwd0_q     <= fwd0_d;
      fwd1_q     <= fwd1_d;
      mul_busy_q <= mul_busy_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_rob_q  <= mul_rob_d;
    end
  end

  assign fwd0 = fwd0_q;
  assign fwd1 = fwd1_q;

endmodule

// File: doc/issue_exec.md
Name: issue_exec

Overview:
- Consumes the two head entries presented by the issue queue and decides, in the same cycle, how many to take (0/1/2), strictly in order.
- Executes taken entries on two 16-bit ALU lanes. Lane 0 also owns a 2-cycle multiplier.
- Broadcasts results as 23-bit forward packets. These feed back into the queue's forward inputs and into this block's own operand bypass.

Parameters:
- DATA_W, 16, operand/result width
- TAG_W, 6, ROB tag width
- ENTRY_W, 57, queue entry packet width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  squash all in-flight work this cycle
- entry0  in  57  head entry: [56] valid, [55:52] op, [51:46] rob, [45:40] lookA, [39:34] lookB, [33:18] valueA, [17:2] valueB, [1] A pending, [0] B pending
- entry1  in  57  head+1 entry, same format
- fwdInA..fwdInD  in  23 each  forward buses: [22] valid, [21:16] tag, [15:0] value
- taken  out  2  entries consumed this cycle (0, 1 or 2); combinational
- fwd0  out  23  lane 0 result broadcast {valid, rob, result}; registered
- fwd1  out  23  lane 1 result broadcast; registered

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: fwd0 = 0, fwd1 = 0, mul_busy = 0, mul pipeline register = 0. taken evaluates to 0 while mul_busy = 0 and no entry is ready.
- Operand resolution, per entry and per operand:
  - Pending bit clear: use the stored value.
  - Pending bit set: compare the look tag against fwdInA..D, lowest letter wins on multiple hits. A valid bus with a matching tag supplies the value (same-cycle bypass). Otherwise the operand is unresolved.
- Ready = valid AND both operands resolved.
- Issue rules, all combinational:
  - taken = 0 if flush, or mul_busy, or entry0 not ready.
  - taken = 1 if entry0 ready and any of: entry0 op is MUL; entry1 not ready; entry1 op is MUL.
  - Otherwise taken = 2.
  - MUL issues only from slot 0. No out-of-order issue: entry1 is never taken alone.
- Ops (4-bit), executed by both lanes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SHL (shift by B[3:0]), 6 SHR logical (by B[3:0])
  - 7 MUL, lane 0 only; result is the low 16 bits of A*B
  - 8 MOV (result = B)
  - 9 SLTU (result = 1 if A<B unsigned, else 0)
  - 10–15 produce result 0 with a valid broadcast
  - All arithmetic wraps modulo 2^16.
- Latency, non-MUL: issue in cycle N; fwd0/fwd1 valid in cycle N+1 for exactly one cycle. A lane that issued nothing drives valid = 0.
- Latency, MUL: issue in cycle N.
  - Operands and rob are captured at edge N+1; mul_busy = 1 during cycle N+1 and taken is forced to 0.
  - fwd0 carries the MUL result in cycle N+2, and mul_busy clears at that same edge.
  - Issue may resume in cycle N+2.
  - fwd1 is invalid for the whole MUL sequence.
- Flush: squashes everything in flight.
  - taken = 0 that cycle.
  - Next edge: fwd0/fwd1 valid = 0 and mul_busy = 0; the captured MUL is dropped and never broadcast.
  - A flush in cycle N+1 of a MUL suppresses its N+2 broadcast.
- Reset mid-operation takes effect immediately. Outputs clear without waiting for an edge; any pending MUL is lost.
- Invalid entries (valid = 0) are never ready, regardless of pending bits.
- Tag 0 is a legal tag; a bus match requires bus valid = 1.

Decomposition:
- Shared package `ooo_pkg`:
  - opcode constants
  - entry field offsets (VALID, OP, ROB, LOOKA, LOOKB, VALA, VALB, USE)
  - forward packet offsets
  - DATA_W, TAG_W
- Sub-module `alu16`: combinational lane (op, A, B → result), instantiated twice. MUL is handled outside it in lane 0's registered path.
- Operand-bypass mux is a function, used four times.

Test Plan:
- entry0 ADD A=5 B=7 rob=3, entry1 SUB A=9 B=4 rob=4, both ready → taken=2; next cycle fwd0={1,3,12}, fwd1={1,4,5}.
- entry0 A pending lookA=10, fwdInC={1,10,0x0020}, B=0x0001 op ADD → taken=1 same cycle; next cycle fwd0 value 0x0021.
- entry0 not ready, entry1 ready → taken=0; fwd0/fwd1 valid=0 next cycle.
- entry0 MUL A=0x0100 B=0x0101 rob=7, entry1 ready ADD → taken=1; next cycle taken=0 even with ready entries; following cycle fwd0={1,7,0x0100}.
- MUL issued, flush asserted in the busy cycle → fwd0 never shows rob 7; taken may be nonzero the cycle after flush.
- rst_n low mid-MUL → fwd0/fwd1 = 0 immediately; after release, taken follows entry readiness with no stale broadcast.
